// File: rtl/xfipcs_pkg.sv
// Shared XFI PCS definitions: sync-header codes, lock-FSM states and default window sizes.
package xfipcs_pkg;

    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    localparam int unsigned SH_CNT_MAX_DEF   = 64;
    localparam int unsigned SH_INVLD_MAX_DEF = 16;
    localparam int unsigned SLIP_WAIT_DEF    = 4;
    localparam int unsigned SLIPCNT_W_DEF    = 16;

    typedef enum logic [1:0] {
        LOCK_INIT    = 2'd0,
        TEST_SH      = 2'd1,
        SLIP_ST      = 2'd2,
        SLIP_WAIT_ST = 2'd3
    } lock_state_e;

    // Only 01 (data) and 10 (control) are legal 64b/66b sync headers.
    function automatic logic sh_is_valid(input logic [1:0] sh);
        return (sh == SH_DATA) || (sh == SH_CTRL);
    endfunction

endpackage

// File: rtl/xfipcs_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module xfipcs_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/xfipcs_66b_block_lock.sv
// Rx 66b block-lock controller: slips the gearbox until sync headers hold, then asserts lock.
module xfipcs_66b_block_lock
    import xfipcs_pkg::*;
#(
    parameter int unsigned SH_CNT_MAX   = SH_CNT_MAX_DEF,
    parameter int unsigned SH_INVLD_MAX = SH_INVLD_MAX_DEF,
    parameter int unsigned SLIP_WAIT    = SLIP_WAIT_DEF,
    parameter int unsigned SLIPCNT_W    = SLIPCNT_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 lock_en_i,
    input  logic                 sh_valid_i,
    input  logic [1:0]           sh_in_i,
    output logic                 slip_o,
    output logic                 block_lock_o,
    output logic                 blk_valid_c_o,
    output logic [SLIPCNT_W-1:0] slip_count_o
);

    localparam int unsigned SH_CNT_W = $clog2(SH_CNT_MAX + 1);
    localparam int unsigned INVLD_W  = $clog2(SH_INVLD_MAX + 1);
    localparam int unsigned WAIT_W   = $clog2(SLIP_WAIT + 1);

    lock_state_e         state_q, state_d;
    logic [SH_CNT_W-1:0] sh_cnt_q, sh_cnt_d, sh_nxt;
    logic [INVLD_W-1:0]  invld_cnt_q, invld_cnt_d, inv_nxt;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                block_lock_q, block_lock_d;
    logic                slip_q, slip_d;
    logic                sh_invalid;

    // Next-state, window counters and registered-output decode.
    always_comb begin
        state_d      = state_q;
        sh_cnt_d     = sh_cnt_q;
        invld_cnt_d  = invld_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        block_lock_d = block_lock_q;
        slip_d       = 1'b0;
        sh_invalid   = !sh_is_valid(sh_in_i);
        sh_nxt       = sh_cnt_q + SH_CNT_W'(1);
        inv_nxt      = invld_cnt_q + INVLD_W'(sh_invalid);

        if (!lock_en_i) begin
            state_d      = LOCK_INIT;
            sh_cnt_d     = '0;
            invld_cnt_d  = '0;
            wait_cnt_d   = '0;
            block_lock_d = 1'b0;
        end else begin
            case (state_q)
                LOCK_INIT: begin
                    sh_cnt_d     = '0;
                    invld_cnt_d  = '0;
                    block_lock_d = 1'b0;
                    state_d      = TEST_SH;
                end
                TEST_SH: begin
                    if (sh_valid_i) begin
                        if (sh_invalid && (!block_lock_q || (inv_nxt == INVLD_W'(SH_INVLD_MAX)))) begin
                            state_d      = SLIP_ST;
                            slip_d       = 1'b1;
                            block_lock_d = 1'b0;
                            sh_cnt_d     = '0;
                            invld_cnt_d  = '0;
                        end else if (sh_nxt == SH_CNT_W'(SH_CNT_MAX)) begin
                            // Window closed; a clean window grants lock, otherwise lock is kept.
                            sh_cnt_d    = '0;
                            invld_cnt_d = '0;
                            if (inv_nxt == '0) begin
                                block_lock_d = 1'b1;
                            end
                        end else begin
                            sh_cnt_d    = sh_nxt;
                            invld_cnt_d = inv_nxt;
                        end
                    end
                end
                SLIP_ST: begin
                    sh_cnt_d    = '0;
                    invld_cnt_d = '0;
                    wait_cnt_d  = '0;
                    state_d     = SLIP_WAIT_ST;
                end
                SLIP_WAIT_ST: begin
                    // Gearbox output is unstable right after a slip; ignore headers meanwhile.
                    if (wait_cnt_q == WAIT_W'(SLIP_WAIT - 1)) begin
                        wait_cnt_d  = '0;
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                        state_d     = TEST_SH;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
                default: begin
                    state_d = LOCK_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= LOCK_INIT;
            sh_cnt_q     <= '0;
            invld_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            block_lock_q <= 1'b0;
            slip_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_cnt_q     <= sh_cnt_d;
            invld_cnt_q  <= invld_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            block_lock_q <= block_lock_d;
            slip_q       <= slip_d;
        end
    end

    xfipcs_sat_counter #(
        .WIDTH(SLIPCNT_W)
    ) u_slip_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clr_i  (1'b0),
        .inc_i  (slip_d),
        .count_o(slip_count_o)
    );

    assign slip_o        = slip_q;
    assign block_lock_o  = block_lock_q;
    assign blk_valid_c_o = sh_valid_i && block_lock_q && (state_q == TEST_SH);

endmodule

// File: tb/tb_xfipcs_66b_block_lock.sv
// Directed bench for the 66b block-lock controller (8-bit slip counter to reach saturation quickly).
module tb_xfipcs_66b_block_lock;

    logic       clk = 1'b0;
    logic       reset;
    logic       lock_en;
    logic       sh_valid;
    logic [1:0] sh_in;
    logic       slip;
    logic       lock;
    logic       blkv;
    logic [7:0] cnt;

    int checks = 0;
    int passes = 0;
    int pulses = 0;
    int consec = 0;
    int p0     = 0;
    logic slip_prev = 1'b0;

    always #5 clk = ~clk;

    xfipcs_66b_block_lock #(
        .SH_CNT_MAX  (64),
        .SH_INVLD_MAX(16),
        .SLIP_WAIT   (4),
        .SLIPCNT_W   (8)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .lock_en_i    (lock_en),
        .sh_valid_i   (sh_valid),
        .sh_in_i      (sh_in),
        .slip_o       (slip),
        .block_lock_o (lock),
        .blk_valid_c_o(blkv),
        .slip_count_o (cnt)
    );

    // Slip pulse monitor: total pulses and back-to-back occurrences.
    always @(posedge clk) begin
        if (slip) pulses++;
        if (slip && slip_prev) consec++;
        slip_prev = slip;
    end

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic blk(input logic v, input logic [1:0] sh, input int n);
        repeat (n) begin
            sh_valid = v;
            sh_in    = sh;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1; lock_en = 1'b0; sh_valid = 1'b0; sh_in = 2'b00;
        blk(1'b0, 2'b00, 2);
        ck("rst_lock", 32'(lock), 32'd0);
        ck("rst_slip", 32'(slip), 32'd0);
        ck("rst_cnt", 32'(cnt), 32'd0);
        sh_valid = 1'b1; #1;
        ck("rst_blkv", 32'(blkv), 32'd0);

        // Initial acquisition: 64 clean headers
        reset = 1'b0; lock_en = 1'b1;
        blk(1'b0, 2'b00, 1);
        blk(1'b1, 2'b01, 63);
        ck("t1_lock63", 32'(lock), 32'd0);
        blk(1'b1, 2'b10, 1);
        ck("t1_lock64", 32'(lock), 32'd1);
        ck("t1_noslip", 32'(pulses), 32'd0);

        // Locked window with 15 invalid headers keeps lock
        sh_valid = 1'b1; sh_in = 2'b00; #1;
        ck("t3_blkv", 32'(blkv), 32'd1);
        for (int i = 0; i < 15; i++) blk(1'b1, (i % 2 == 0) ? 2'b00 : 2'b11, 1);
        blk(1'b1, 2'b01, 49);
        ck("t3_held", 32'(lock), 32'd1);
        ck("t3_noslip", 32'(pulses), 32'd0);

        // 16th invalid at block 20 drops lock and slips
        blk(1'b1, 2'b01, 4);
        blk(1'b1, 2'b00, 15);
        ck("t3_lock19", 32'(lock), 32'd1);
        ck("t3_slip19", 32'(slip), 32'd0);
        blk(1'b1, 2'b11, 1);
        ck("t3_slip20", 32'(slip), 32'd1);
        ck("t3_lock20", 32'(lock), 32'd0);
        ck("t3_cnt", 32'(cnt), 32'd1);

        // Post-slip headers ignored, then reacquire
        blk(1'b1, 2'b00, 1);
        ck("t2_slip1cyc", 32'(slip), 32'd0);
        blk(1'b1, 2'b00, 4);
        ck("t2_ignored", 32'(pulses), 32'd1);
        blk(1'b1, 2'b01, 63);
        ck("t2_lock63", 32'(lock), 32'd0);
        blk(1'b1, 2'b01, 1);
        ck("t2_lock64", 32'(lock), 32'd1);

        // Invalid only on last block of window: lock held, counters restart
        blk(1'b1, 2'b01, 63);
        blk(1'b1, 2'b00, 1);
        ck("t4_lock", 32'(lock), 32'd1);
        ck("t4_noslip", 32'(pulses), 32'd1);
        blk(1'b1, 2'b11, 15);
        ck("t4_clr_slip", 32'(slip), 32'd0);
        ck("t4_clr_lock", 32'(lock), 32'd1);
        blk(1'b1, 2'b00, 1);
        ck("t4_slip16", 32'(slip), 32'd1);
        ck("t4_cnt", 32'(cnt), 32'd2);

        // Unlocked: first invalid header slips
        blk(1'b0, 2'b00, 5);
        blk(1'b1, 2'b00, 1);
        ck("t2_first_slip", 32'(slip), 32'd1);
        ck("t2_cnt", 32'(cnt), 32'd3);

        // LOCK_EN low during SLIP_WAIT
        blk(1'b0, 2'b00, 1);
        lock_en = 1'b0;
        blk(1'b0, 2'b00, 1);
        ck("t6_wait_slip", 32'(slip), 32'd0);
        ck("t6_wait_cnt", 32'(cnt), 32'd3);
        ck("t6_wait_lock", 32'(lock), 32'd0);

        // LOCK_EN low mid-window beats an invalid header
        lock_en = 1'b1;
        blk(1'b0, 2'b00, 1);
        blk(1'b1, 2'b01, 30);
        lock_en = 1'b0;
        blk(1'b1, 2'b00, 1);
        ck("t6_en_slip", 32'(slip), 32'd0);
        ck("t6_en_cnt", 32'(cnt), 32'd3);
        lock_en = 1'b1;
        blk(1'b0, 2'b00, 1);
        blk(1'b1, 2'b01, 63);
        ck("t6_clr_lock63", 32'(lock), 32'd0);
        blk(1'b1, 2'b01, 1);
        ck("t6_clr_lock64", 32'(lock), 32'd1);
        lock_en = 1'b0;
        blk(1'b1, 2'b01, 1);
        ck("t6_drop_lock", 32'(lock), 32'd0);

        // RESET during SLIP_ST
        lock_en = 1'b1;
        blk(1'b0, 2'b00, 1);
        blk(1'b1, 2'b11, 1);
        ck("t6_pre_slip", 32'(slip), 32'd1);
        ck("t6_pre_cnt", 32'(cnt), 32'd4);
        reset = 1'b1;
        blk(1'b1, 2'b11, 1);
        ck("t6_rst_slip", 32'(slip), 32'd0);
        ck("t6_rst_cnt", 32'(cnt), 32'd0);
        ck("t6_rst_lock", 32'(lock), 32'd0);

        // Constant SH=11: slips every 6 cycles, counter saturates
        reset = 1'b0;
        blk(1'b0, 2'b00, 1);
        p0 = pulses;
        blk(1'b1, 2'b11, 1);
        ck("t5_first_slip", 32'(slip), 32'd1);
        ck("t5_first_cnt", 32'(cnt), 32'd1);
        blk(1'b1, 2'b11, 1699);
        ck("t5_pulses", 32'(pulses - p0), 32'd284);
        ck("t5_sat", 32'(cnt), 32'hFF);
        ck("no_consec_slip", 32'(consec), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
